// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM pins, pipeline control from ID/exception logic,
// and the IF/ID register outputs toward decode.
interface instr_fetch_if;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        fetch_err;
  logic [31:0] fetch_err_pc;
  logic [31:0] fetch_count;

  modport master (
    output rom_ce, rom_addr,
    input  rom_instr,
    input  stall, branch_flag, branch_target, flush, flush_pc,
    output id_pc, id_instr, id_valid,
    output fetch_err, fetch_err_pc, fetch_count
  );

  modport slave (
    input  rom_ce, rom_addr,
    output rom_instr,
    output stall, branch_flag, branch_target, flush, flush_pc,
    input  id_pc, id_instr, id_valid,
    input  fetch_err, fetch_err_pc, fetch_count
  );
endinterface

// File: rtl/instr_fetch.sv
// PC generation and IF/ID register: sequential fetch, stall, branch redirect
// with optional delay slot, exception flush and misaligned-target halt.
//
//   state | meaning
//   IDLE  | out of reset, ROM disabled; next edge starts fetching at RESET_PC
//   RUN   | fetching, ROM enabled
//   HALT  | misaligned redirect seen, ROM disabled; left only by flush or reset
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] id_pc, id_pc_nxt;
  logic [31:0] id_instr, id_instr_nxt;
  logic        id_valid, id_valid_nxt;
  logic        fetch_err, fetch_err_nxt;
  logic [31:0] fetch_err_pc, fetch_err_pc_nxt;
  logic [31:0] fetch_count, fetch_count_nxt;
  logic [31:0] redirect_tgt;
  logic        redirect;
  logic        advance;

  assign bus.rom_ce       = (state == RUN);
  assign bus.rom_addr     = pc;
  assign bus.id_pc        = id_pc;
  assign bus.id_instr     = id_instr;
  assign bus.id_valid     = id_valid;
  assign bus.fetch_err    = fetch_err;
  assign bus.fetch_err_pc = fetch_err_pc;
  assign bus.fetch_count  = fetch_count;

  // Flush wins over branch, and is honoured in HALT where branches are not.
  assign redirect_tgt = bus.flush ? bus.flush_pc : bus.branch_target;
  assign redirect     = bus.flush || ((state == RUN) && bus.branch_flag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      id_pc        <= 32'h0;
      id_instr     <= 32'h0;
      id_valid     <= 1'b0;
      fetch_err    <= 1'b0;
      fetch_err_pc <= 32'h0;
      fetch_count  <= 32'h0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      id_pc        <= id_pc_nxt;
      id_instr     <= id_instr_nxt;
      id_valid     <= id_valid_nxt;
      fetch_err    <= fetch_err_nxt;
      fetch_err_pc <= fetch_err_pc_nxt;
      fetch_count  <= fetch_count_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    id_pc_nxt        = id_pc;
    id_instr_nxt     = id_instr;
    id_valid_nxt     = id_valid;
    fetch_err_nxt    = fetch_err;
    fetch_err_pc_nxt = fetch_err_pc;
    fetch_count_nxt  = fetch_count;
    advance          = 1'b0;

    unique case (state)
      IDLE: state_nxt = RUN;
      RUN, HALT: begin
        if (redirect) begin
          if (redirect_tgt[1:0] != 2'b00) begin
            state_nxt        = HALT;
            fetch_err_nxt    = 1'b1;
            fetch_err_pc_nxt = redirect_tgt;
            id_valid_nxt     = 1'b0;
            id_instr_nxt     = 32'h0;
          end else begin
            state_nxt = RUN;
            pc_nxt    = redirect_tgt;
            if (!bus.flush && DELAY_SLOT) begin
              advance = 1'b1;
            end else begin
              id_valid_nxt = 1'b0;
              id_instr_nxt = 32'h0;
            end
          end
        end else if (state == HALT) begin
          id_valid_nxt = 1'b0;
        end else if (!bus.stall) begin
          advance = 1'b1;
          pc_nxt  = pc + 32'd4;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (advance) begin
      id_pc_nxt       = pc;
      id_instr_nxt    = bus.rom_instr;
      id_valid_nxt    = 1'b1;
      fetch_count_nxt = fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: one instance per delay-slot setting, both
// compared every edge against a behavioural fetch model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_if bus0 ();
  instr_fetch_if bus1 ();

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h00:  rom_word = 32'h3401_0011;  // ori   $1,$0,0x11
      32'h04:  rom_word = 32'h0021_1026;  // xor   $2,$1,$1
      32'h08:  rom_word = 32'h0022_1821;  // addu  $3,$1,$2
      32'h0C:  rom_word = 32'h2464_0004;  // addiu $4,$3,4
      default: rom_word = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign bus0.rom_instr     = rom_word(bus0.rom_addr);
  assign bus0.stall         = stall;
  assign bus0.branch_flag   = branch_flag;
  assign bus0.branch_target = branch_target;
  assign bus0.flush         = flush;
  assign bus0.flush_pc      = flush_pc;
  assign bus1.rom_instr     = rom_word(bus1.rom_addr);
  assign bus1.stall         = stall;
  assign bus1.branch_flag   = branch_flag;
  assign bus1.branch_target = branch_target;
  assign bus1.flush         = flush;
  assign bus1.flush_pc      = flush_pc;

  instr_fetch #(.RESET_PC(32'h0), .DELAY_SLOT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  instr_fetch #(.RESET_PC(32'h0), .DELAY_SLOT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Model: index 0 is the no-delay-slot instance, index 1 the delay-slot one.
  bit          m_started [2];
  bit          m_halted  [2];
  logic [31:0] m_pc      [2];
  logic [31:0] m_idpc    [2];
  logic [31:0] m_idinstr [2];
  bit          m_idvalid [2];
  bit          m_err     [2];
  logic [31:0] m_errpc   [2];
  logic [31:0] m_cnt     [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_started[i] = 0; m_halted[i] = 0; m_pc[i] = 32'h0;
      m_idpc[i] = 32'h0; m_idinstr[i] = 32'h0; m_idvalid[i] = 0;
      m_err[i] = 0; m_errpc[i] = 32'h0; m_cnt[i] = 32'h0;
    end
  endtask

  task automatic model_deliver(input int i);
    m_idpc[i]    = m_pc[i];
    m_idinstr[i] = rom_word(m_pc[i]);
    m_idvalid[i] = 1;
    m_cnt[i]     = m_cnt[i] + 1;
  endtask

  task automatic model_halt(input int i, input logic [31:0] t);
    m_halted[i]  = 1;
    m_err[i]     = 1;
    m_errpc[i]   = t;
    m_idvalid[i] = 0;
    m_idinstr[i] = 32'h0;
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!m_started[i]) begin
        m_started[i] = 1;
      end else if (flush) begin
        if (flush_pc[1:0] != 2'b00) model_halt(i, flush_pc);
        else begin
          m_halted[i] = 0; m_pc[i] = flush_pc;
          m_idvalid[i] = 0; m_idinstr[i] = 32'h0;
        end
      end else if (m_halted[i]) begin
        m_idvalid[i] = 0;
      end else if (branch_flag) begin
        if (branch_target[1:0] != 2'b00) model_halt(i, branch_target);
        else begin
          if (i == 1) model_deliver(i);
          else begin m_idvalid[i] = 0; m_idinstr[i] = 32'h0; end
          m_pc[i] = branch_target;
        end
      end else if (!stall) begin
        model_deliver(i);
        m_pc[i] = m_pc[i] + 32'd4;
      end
    end
  endtask

  task automatic check_all();
    check("ds0.rom_ce",       {31'h0, bus0.rom_ce},   {31'h0, m_started[0] && !m_halted[0]});
    check("ds0.rom_addr",     bus0.rom_addr,          m_pc[0]);
    check("ds0.id_pc",        bus0.id_pc,             m_idpc[0]);
    check("ds0.id_instr",     bus0.id_instr,          m_idinstr[0]);
    check("ds0.id_valid",     {31'h0, bus0.id_valid}, {31'h0, m_idvalid[0]});
    check("ds0.fetch_err",    {31'h0, bus0.fetch_err},{31'h0, m_err[0]});
    check("ds0.fetch_err_pc", bus0.fetch_err_pc,      m_errpc[0]);
    check("ds0.fetch_count",  bus0.fetch_count,       m_cnt[0]);
    check("ds1.rom_ce",       {31'h0, bus1.rom_ce},   {31'h0, m_started[1] && !m_halted[1]});
    check("ds1.rom_addr",     bus1.rom_addr,          m_pc[1]);
    check("ds1.id_pc",        bus1.id_pc,             m_idpc[1]);
    check("ds1.id_instr",     bus1.id_instr,          m_idinstr[1]);
    check("ds1.id_valid",     {31'h0, bus1.id_valid}, {31'h0, m_idvalid[1]});
    check("ds1.fetch_err",    {31'h0, bus1.fetch_err},{31'h0, m_err[1]});
    check("ds1.fetch_err_pc", bus1.fetch_err_pc,      m_errpc[1]);
    check("ds1.fetch_count",  bus1.fetch_count,       m_cnt[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic set_in(input bit s, input bit b, input logic [31:0] bt,
                        input bit f, input logic [31:0] fp);
    stall = s; branch_flag = b; branch_target = bt; flush = f; flush_pc = fp;
  endtask

  initial begin
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    tick();
    check("start.rom_ce", {31'h0, bus1.rom_ce}, 32'h1);
    check("start.rom_addr", bus1.rom_addr, 32'h0);

    repeat (2) tick();
    set_in(1, 0, 0, 0, 0);
    repeat (3) tick();
    check("stall.rom_addr", bus1.rom_addr, 32'h8);
    check("stall.id_pc", bus1.id_pc, 32'h4);
    set_in(0, 0, 0, 0, 0);
    repeat (3) tick();
    check("seq.fetch_count", bus1.fetch_count, 32'd5);

    set_in(1, 1, 32'h8, 0, 0);
    tick();
    check("br.rom_addr", bus1.rom_addr, 32'h8);
    check("br.ds1_id_pc", bus1.id_pc, 32'h14);
    check("br.ds0_id_valid", {31'h0, bus0.id_valid}, 32'h0);
    set_in(0, 0, 0, 0, 0);
    repeat (2) tick();

    set_in(1, 0, 0, 1, 32'h40);
    tick();
    check("flush.rom_addr", bus1.rom_addr, 32'h40);
    set_in(0, 0, 0, 0, 0);
    tick();
    check("flush.next_id_pc", bus1.id_pc, 32'h40);

    set_in(0, 1, 32'h6, 0, 0);
    tick();
    check("mis.fetch_err_pc", bus0.fetch_err_pc, 32'h6);
    check("mis.rom_ce", {31'h0, bus0.rom_ce}, 32'h0);
    set_in(1, 1, 32'h20, 0, 0);
    repeat (2) tick();
    set_in(0, 0, 0, 1, 32'h0);
    tick();
    check("resume.fetch_err", {31'h0, bus1.fetch_err}, 32'h1);
    set_in(0, 0, 0, 0, 0);
    repeat (2) tick();

    set_in(0, 1, 32'hFFFF_FFFC, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0);
    tick();
    check("wrap.rom_addr", bus1.rom_addr, 32'h0);
    tick();

    for (int n = 0; n < 400; n++) begin
      logic [31:0] bt, fp;
      bt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 11) == 0) bt[1:0] = 2'($urandom_range(1, 3));
      fp = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 9) == 0) fp[1:0] = 2'($urandom_range(1, 3));
      set_in($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 12, bt,
             $urandom_range(0, 99) < 5, fp);
      tick();
    end

    set_in(0, 0, 0, 0, 0);
    repeat (3) tick();
    @(posedge clk);
    model_step();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst.rom_ce", {31'h0, bus1.rom_ce}, 32'h0);
    check("arst.id_valid", {31'h0, bus1.id_valid}, 32'h0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
